// File: rtl/movegen_pkg.sv
// Shared types and piece encodings for the move-generation sequencer and its helpers.
package movegen_pkg;

    localparam logic [2:0] PC_EMPTY = 3'd0;
    localparam logic [2:0] PC_K     = 3'd1;
    localparam logic [2:0] PC_Q     = 3'd2;
    localparam logic [2:0] PC_R     = 3'd3;
    localparam logic [2:0] PC_B     = 3'd4;
    localparam logic [2:0] PC_N     = 3'd5;
    localparam logic [2:0] PC_P     = 3'd6;
    localparam int unsigned COLOUR_BIT = 3;

    typedef logic [5:0]  sq_idx_t;
    typedef logic [63:0] board_vec_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StScan,
        StSettle,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/movegen_lsb64.sv
// Combinational lowest-set-bit encoder: 64-bit vector to 6-bit index plus any-set flag.
module movegen_lsb64
    import movegen_pkg::*;
(
    input  board_vec_t i_vec,
    output sq_idx_t    o_idx,
    output logic       o_any
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        o_idx = '0;
        for (int i = 63; i >= 0; i--) begin
            if (i_vec[i]) o_idx = sq_idx_t'(i);
        end
    end

    assign o_any = |i_vec;

endmodule

// File: rtl/movegen_sequencer.sv
// Loads a position into the 64-square movegen array, strobes each own piece in turn and
// streams the resulting (from,to) pairs to the move list.
module movegen_sequencer
    import movegen_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned COUNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_wtp,
    input  logic [3:0]         i_castle_rights,
    input  logic               i_sq_valid,
    input  logic [3:0]         i_sq_data,
    output logic               o_sq_ready,
    output logic               o_pos_valid,
    output logic [3:0]         o_pos_data,
    output logic               o_wtp,
    output logic [3:0]         o_castle_rights,
    output board_vec_t         o_emit,
    input  board_vec_t         i_target,
    output logic               o_move_valid,
    input  logic               i_move_ready,
    output sq_idx_t            o_move_from,
    output sq_idx_t            o_move_to,
    output logic               o_busy,
    output logic               o_done,
    output logic [COUNT_W-1:0] o_move_count
);

    localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_e               state_q, state_d;
    logic                 wtp_q, wtp_d;
    logic [3:0]           castle_q, castle_d;
    board_vec_t           own_q, own_d;
    board_vec_t           tgt_q, tgt_d;
    sq_idx_t              sq_cnt_q, sq_cnt_d;
    sq_idx_t              src_q, src_d;
    logic [SettleW-1:0]   settle_q, settle_d;
    logic [COUNT_W-1:0]   count_q, count_d;

    logic                 beat;
    logic                 drain;
    sq_idx_t              lsb_idx;
    logic                 lsb_any;

    movegen_lsb64 u_lsb (
        .i_vec (tgt_q),
        .o_idx (lsb_idx),
        .o_any (lsb_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            wtp_q    <= 1'b0;
            castle_q <= '0;
            own_q    <= '0;
            tgt_q    <= '0;
            sq_cnt_q <= '0;
            src_q    <= '0;
            settle_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wtp_q    <= wtp_d;
            castle_q <= castle_d;
            own_q    <= own_d;
            tgt_q    <= tgt_d;
            sq_cnt_q <= sq_cnt_d;
            src_q    <= src_d;
            settle_q <= settle_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wtp_d    = wtp_q;
        castle_d = castle_q;
        own_d    = own_q;
        tgt_d    = tgt_q;
        sq_cnt_d = sq_cnt_q;
        src_d    = src_q;
        settle_d = settle_q;
        count_d  = count_q;
        beat     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d  = StLoad;
                    wtp_d    = i_wtp;
                    castle_d = i_castle_rights;
                    count_d  = '0;
                    sq_cnt_d = '0;
                    own_d    = '0;
                    src_d    = '0;
                end
            end
            StLoad: begin
                if (i_sq_valid) begin
                    beat = 1'b1;
                    // First nibble shifts furthest down the chain, ending in square 63.
                    if (i_sq_data[2:0] != PC_EMPTY && i_sq_data[COLOUR_BIT] == wtp_q) begin
                        own_d[6'd63 - sq_cnt_q] = 1'b1;
                    end
                    sq_cnt_d = sq_cnt_q + 6'd1;
                    if (sq_cnt_q == 6'd63) begin
                        state_d = StScan;
                        src_d   = '0;
                    end
                end
            end
            StScan: begin
                if (own_q[src_q]) begin
                    state_d  = StSettle;
                    settle_d = '0;
                end else if (src_q == 6'd63) begin
                    state_d = StDone;
                end else begin
                    src_d = src_q + 6'd1;
                end
            end
            StSettle: begin
                if (settle_q == SettleW'(SETTLE_CYCLES - 1)) begin
                    tgt_d   = i_target;
                    state_d = StDrain;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            StDrain: begin
                if (lsb_any) begin
                    if (i_move_ready) begin
                        tgt_d[lsb_idx] = 1'b0;
                        if (count_q != '1) count_d = count_q + 1'b1;
                    end
                end else if (src_q == 6'd63) begin
                    state_d = StDone;
                end else begin
                    src_d   = src_q + 6'd1;
                    state_d = StScan;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign drain           = (state_q == StDrain);
    assign o_sq_ready      = (state_q == StLoad);
    assign o_pos_valid     = beat;
    assign o_pos_data      = beat ? i_sq_data : 4'd0;
    assign o_wtp           = wtp_q;
    assign o_castle_rights = castle_q;
    assign o_emit          = (state_q == StSettle) ? (board_vec_t'(1) << src_q) : '0;
    assign o_move_valid    = drain & lsb_any;
    assign o_move_from     = drain ? src_q : '0;
    assign o_move_to       = drain ? lsb_idx : '0;
    assign o_busy          = (state_q != StIdle);
    assign o_done          = (state_q == StDone);
    assign o_move_count    = count_q;

endmodule

// File: tb/tb_movegen_sequencer.sv
// Directed bench: models a knight/pawn-only square array around the sequencer.
module tb_movegen_sequencer;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic        i_wtp;
    logic [3:0]  i_castle_rights;
    logic        i_sq_valid;
    logic [3:0]  i_sq_data;
    logic        o_sq_ready;
    logic        o_pos_valid;
    logic [3:0]  o_pos_data;
    logic        o_wtp;
    logic [3:0]  o_castle_rights;
    logic [63:0] o_emit;
    logic [63:0] i_target;
    logic        o_move_valid;
    logic        i_move_ready;
    logic [5:0]  o_move_from;
    logic [5:0]  o_move_to;
    logic        o_busy;
    logic        o_done;
    logic [7:0]  o_move_count;

    int vectors;
    int miscompares;

    logic [3:0]  board [64];
    logic [11:0] exp_q [$];
    logic [11:0] got_q [$];
    bit          done_seen;
    bit          emit_seen;
    int          kdf [8] = '{1, -1, 1, -1, 2, 2, -2, -2};
    int          kdr [8] = '{2, 2, -2, -2, 1, -1, 1, -1};

    movegen_sequencer #(
        .SETTLE_CYCLES (2),
        .COUNT_W       (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (i_start),
        .i_wtp           (i_wtp),
        .i_castle_rights (i_castle_rights),
        .i_sq_valid      (i_sq_valid),
        .i_sq_data       (i_sq_data),
        .o_sq_ready      (o_sq_ready),
        .o_pos_valid     (o_pos_valid),
        .o_pos_data      (o_pos_data),
        .o_wtp           (o_wtp),
        .o_castle_rights (o_castle_rights),
        .o_emit          (o_emit),
        .i_target        (i_target),
        .o_move_valid    (o_move_valid),
        .i_move_ready    (i_move_ready),
        .o_move_from     (o_move_from),
        .o_move_to       (o_move_to),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_move_count    (o_move_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit can_land(int sq, bit white);
        return (board[sq][2:0] == 3'd0) || (board[sq][3] != white);
    endfunction

    // Only knights and pawns generate targets; every position used here has other pieces blocked.
    function automatic logic [63:0] targets_of(int src);
        logic [63:0] t;
        logic [3:0]  p;
        bit          white;
        int          f, r, nf, nr, dir;
        t     = '0;
        p     = board[src];
        white = p[3];
        f     = src % 8;
        r     = src / 8;
        if (p[2:0] == 3'd5) begin
            for (int k = 0; k < 8; k++) begin
                nf = f + kdf[k];
                nr = r + kdr[k];
                if (nf >= 0 && nf < 8 && nr >= 0 && nr < 8 && can_land(nr * 8 + nf, white))
                    t[nr * 8 + nf] = 1'b1;
            end
        end else if (p[2:0] == 3'd6) begin
            dir = white ? 1 : -1;
            nr  = r + dir;
            if (nr >= 0 && nr < 8) begin
                if (board[nr * 8 + f] == 4'd0) begin
                    t[nr * 8 + f] = 1'b1;
                    if (r == (white ? 1 : 6) && board[(nr + dir) * 8 + f] == 4'd0)
                        t[(nr + dir) * 8 + f] = 1'b1;
                end
                for (int d = -1; d <= 1; d += 2) begin
                    nf = f + d;
                    if (nf >= 0 && nf < 8 && board[nr * 8 + nf] != 4'd0 &&
                        board[nr * 8 + nf][3] != white)
                        t[nr * 8 + nf] = 1'b1;
                end
            end
        end
        return t;
    endfunction

    always_comb begin
        i_target = '0;
        for (int i = 0; i < 64; i++) begin
            if (o_emit[i]) i_target = targets_of(i);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_board();
        for (int i = 0; i < 64; i++) board[i] = 4'd0;
    endtask

    task automatic start_board(input bit with_black);
        logic [3:0] back [8];
        back = '{4'd3, 4'd5, 4'd4, 4'd2, 4'd1, 4'd4, 4'd5, 4'd3};
        clear_board();
        for (int f = 0; f < 8; f++) begin
            board[f]     = back[f] | 4'd8;
            board[8 + f] = 4'd14;
            if (with_black) begin
                board[48 + f] = 4'd6;
                board[56 + f] = back[f];
            end
        end
    endtask

    task automatic load_pos(input bit wtp, input logic [3:0] castle, input bit poke_start);
        @(posedge clk); #1;
        i_start         = 1'b1;
        i_wtp           = wtp;
        i_castle_rights = castle;
        @(posedge clk); #1;
        i_start         = 1'b0;
        i_wtp           = ~wtp;
        i_castle_rights = ~castle;
        check_eq("load_busy", o_busy, 1);
        check_eq("load_ready", o_sq_ready, 1);
        for (int b = 0; b < 64; b++) begin
            if (b == 20) begin
                i_sq_valid = 1'b0;
                #1;
                check_eq("gap_pos_valid", o_pos_valid, 0);
                @(posedge clk); #1;
            end
            i_sq_valid = 1'b1;
            i_sq_data  = board[63 - b];
            if (poke_start && b == 10) i_start = 1'b1;
            if (b == 0 || b == 63) begin
                #1;
                check_eq("beat_pos_valid", o_pos_valid, 1);
                check_eq("beat_pos_data", o_pos_data, board[63 - b]);
            end
            @(posedge clk); #1;
            i_start = 1'b0;
            if (poke_start && b == 10) check_eq("poke_still_load", o_sq_ready, 1);
        end
        i_sq_valid = 1'b0;
        i_sq_data  = 4'd0;
        check_eq("post_load_ready", o_sq_ready, 0);
        check_eq("latched_wtp", o_wtp, wtp);
        check_eq("latched_castle", o_castle_rights, castle);
    endtask

    task automatic collect(input int budget, input int stall_idx);
        int         n;
        logic [5:0] hf, ht;
        logic [7:0] hc;
        n         = 0;
        done_seen = 1'b0;
        emit_seen = 1'b0;
        got_q.delete();
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (o_emit != '0) emit_seen = 1'b1;
            if (o_done) begin
                done_seen = 1'b1;
                break;
            end
            if (o_move_valid) begin
                if (n == stall_idx) begin
                    hf = o_move_from;
                    ht = o_move_to;
                    hc = o_move_count;
                    i_move_ready = 1'b0;
                    repeat (5) begin
                        @(negedge clk);
                        check_eq("stall_valid", o_move_valid, 1);
                        check_eq("stall_from", o_move_from, hf);
                        check_eq("stall_to", o_move_to, ht);
                        check_eq("stall_count", o_move_count, hc);
                    end
                end
                i_move_ready = 1'b1;
                got_q.push_back({o_move_from, o_move_to});
                n++;
            end else begin
                i_move_ready = 1'b1;
            end
        end
        check_eq("done_seen", done_seen, 1);
        @(negedge clk);
        check_eq("done_one_cycle", o_done, 0);
        check_eq("idle_after_done", o_busy, 0);
    endtask

    task automatic compare_moves(input string tag);
        int m;
        check_eq({tag, "_nmoves"}, got_q.size(), exp_q.size());
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) check_eq($sformatf("%s_mv%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic knight_run(input int stall_idx);
        clear_board();
        board[0] = 4'd13;
        exp_q.delete();
        exp_q.push_back({6'd0, 6'd10});
        exp_q.push_back({6'd0, 6'd17});
        load_pos(1'b1, 4'h5, 1'b0);
        collect(300, stall_idx);
        compare_moves("knight");
        check_eq("knight_count", o_move_count, 2);
    endtask

    initial begin
        bit seen;
        vectors         = 0;
        miscompares     = 0;
        rst_n           = 1'b0;
        i_start         = 1'b0;
        i_wtp           = 1'b0;
        i_castle_rights = 4'd0;
        i_sq_valid      = 1'b0;
        i_sq_data       = 4'd0;
        i_move_ready    = 1'b1;
        clear_board();

        #3;
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_emit", o_emit, 0);
        check_eq("rst_move_valid", o_move_valid, 0);
        check_eq("rst_count", o_move_count, 0);
        check_eq("rst_wtp", o_wtp, 0);
        check_eq("rst_sq_ready", o_sq_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Start position, white; also pokes i_start mid-load.
        start_board(1'b1);
        exp_q.delete();
        exp_q.push_back({6'd1, 6'd16});
        exp_q.push_back({6'd1, 6'd18});
        exp_q.push_back({6'd6, 6'd21});
        exp_q.push_back({6'd6, 6'd23});
        for (int p = 8; p < 16; p++) begin
            exp_q.push_back({6'(p), 6'(p + 8)});
            exp_q.push_back({6'(p), 6'(p + 16)});
        end
        load_pos(1'b1, 4'hF, 1'b1);
        collect(400, -1);
        compare_moves("start");
        check_eq("start_count", o_move_count, 20);

        // Lone knight with backpressure on the second move.
        knight_run(1);

        // Black to move, only white pieces present.
        start_board(1'b0);
        exp_q.delete();
        load_pos(1'b0, 4'h0, 1'b0);
        collect(80, -1);
        compare_moves("black");
        check_eq("black_no_emit", emit_seen, 0);
        check_eq("black_count", o_move_count, 0);

        // Reset while draining.
        start_board(1'b1);
        load_pos(1'b1, 4'hA, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (o_move_valid) seen = 1'b1;
        end
        check_eq("t5_reached_drain", seen, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_move_valid", o_move_valid, 0);
        check_eq("t5_busy", o_busy, 0);
        check_eq("t5_from_to", {o_move_from, o_move_to}, 0);
        check_eq("t5_count", o_move_count, 0);
        check_eq("t5_castle", o_castle_rights, 0);
        check_eq("t5_emit_done", {o_emit, o_done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        knight_run(-1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
